// File: rtl/end_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : end_text_buffer
// Purpose  : 16x16 character page for the end-of-game overlay ("GAME OVER",
//            "SCORE:" and a 4-digit decimal score), read by char_xy.
// Revision : 1.0 - initial release
// ============================================================================
module end_text_buffer #(
    parameter int MSG_ROW   = 2,
    parameter int SCORE_ROW = 5,
    parameter int SCORE_W   = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    input  logic [7:0]         char_xy,
    output logic [6:0]         char_code,
    output logic               busy,
    output logic               ready
);

    localparam logic [3:0]         c_MSG_ROW   = 4'(MSG_ROW);
    localparam logic [3:0]         c_SCORE_ROW = 4'(SCORE_ROW);
    localparam logic [SCORE_W-1:0] c_MAX_SCORE = SCORE_W'(9999);
    localparam logic [6:0]         c_SPACE     = 7'h20;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_TEXT    = 3'd2,
        S_CONVERT = 3'd3,
        S_DIGITS  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [SCORE_W-1:0] r_bin;
    logic [15:0]        r_bcd;
    logic [6:0]         r_mem [256];

    logic               w_we;
    logic [7:0]         w_waddr;
    logic [6:0]         w_wdata;
    logic [14:0]        w_text;
    logic [15:0]        w_adj;
    logic [3:0]         w_nib;

    // Fixed text table: {address, character} for each of the 15 text cells.
    function automatic logic [14:0] text_entry(input logic [3:0] idx);
        logic [6:0] ch;
        logic [7:0] ad;
        ch = c_SPACE;
        ad = {c_MSG_ROW, 4'(idx + 4'd3)};
        case (idx)
            4'd0:  ch = 7'h47;
            4'd1:  ch = 7'h41;
            4'd2:  ch = 7'h4D;
            4'd3:  ch = 7'h45;
            4'd4:  ch = 7'h20;
            4'd5:  ch = 7'h4F;
            4'd6:  ch = 7'h56;
            4'd7:  ch = 7'h45;
            4'd8:  ch = 7'h52;
            4'd9:  ch = 7'h53;
            4'd10: ch = 7'h43;
            4'd11: ch = 7'h4F;
            4'd12: ch = 7'h52;
            4'd13: ch = 7'h45;
            4'd14: ch = 7'h3A;
            default: ch = c_SPACE;
        endcase
        if (idx >= 4'd9) begin
            ad = {c_SCORE_ROW, 4'(idx - 4'd7)};
        end
        return {ad, ch};
    endfunction

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_text = text_entry(r_cnt[3:0]);
        case (r_cnt[1:0])
            2'd0:    w_nib = r_bcd[15:12];
            2'd1:    w_nib = r_bcd[11:8];
            2'd2:    w_nib = r_bcd[7:4];
            default: w_nib = r_bcd[3:0];
        endcase
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = c_SPACE;
        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
            end
            S_TEXT: begin
                w_we    = 1'b1;
                w_waddr = w_text[14:7];
                w_wdata = w_text[6:0];
            end
            S_DIGITS: begin
                w_we    = 1'b1;
                w_waddr = {c_SCORE_ROW, 4'(r_cnt[3:0] + 4'd9)};
                w_wdata = 7'h30 + {3'b000, w_nib};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_bin   <= '0;
            r_bcd   <= 16'd0;
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE) begin
                        ready <= 1'b1;
                    end
                    if (start) begin
                        r_bin   <= (score > c_MAX_SCORE) ? c_MAX_SCORE : score;
                        r_cnt   <= 8'd0;
                        r_state <= S_CLEAR;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd255) begin
                        r_state <= S_TEXT;
                    end
                end
                S_TEXT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd14) begin
                        r_cnt   <= 8'd0;
                        r_bcd   <= 16'd0;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_bcd <= {w_adj[14:0], r_bin[SCORE_W-1]};
                    r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'(SCORE_W - 1)) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_DIGITS;
                    end
                end
                S_DIGITS: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd3) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Reads are gated by the registered ready so a partial page is never shown.
    always_ff @(posedge clk) begin
        if (rst || !ready) begin
            char_code <= c_SPACE;
        end else begin
            char_code <= r_mem[char_xy];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_end_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_end_text_buffer
// Purpose  : Directed, table-driven bench for end_text_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_end_text_buffer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] score;
    logic [7:0]  char_xy;
    logic [6:0]  char_code;
    logic        busy;
    logic        ready;

    int checks;
    int failures;

    end_text_buffer #(.MSG_ROW(2), .SCORE_ROW(5), .SCORE_W(14)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .score     (score),
        .char_xy   (char_xy),
        .char_code (char_code),
        .busy      (busy),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] sc;
        logic [27:0] digs;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_at(input logic [7:0] a, input logic [27:0] digs);
        string      msg;
        string      scl;
        logic [3:0] row;
        logic [3:0] col;
        msg = "GAME OVER";
        scl = "SCORE:";
        row = a[7:4];
        col = a[3:0];
        if (row == 4'd2 && col >= 4'd3 && col <= 4'd11) return 7'(msg[col - 4'd3]);
        if (row == 4'd5 && col >= 4'd2 && col <= 4'd7)  return 7'(scl[col - 4'd2]);
        if (row == 4'd5 && col >= 4'd9 && col <= 4'd12) return digs[7*(12 - col) +: 7];
        return 7'h20;
    endfunction

    task automatic read_at(input logic [7:0] a, output logic [6:0] code);
        @(negedge clk);
        char_xy = a;
        @(posedge clk);
        #1;
        code = char_code;
    endtask

    task automatic start_pulse(input logic [13:0] sc);
        @(negedge clk);
        score = sc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("ready_after_start", int'(ready), 0);
    endtask

    task automatic wait_ready(input bit inject, output int n);
        n = 0;
        while (!ready && n < 400) begin
            if (inject && n == 100) begin
                score = 14'd5555;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
    endtask

    task automatic check_digits(input string tag, input logic [27:0] digs);
        logic [6:0] code;
        for (int c = 9; c <= 12; c++) begin
            read_at({4'd5, 4'(c)}, code);
            chk($sformatf("%s_digit_col%0d", tag, c), int'(code), int'(digs[7*(12 - c) +: 7]));
        end
    endtask

    task automatic full_build(input string tag, input logic [13:0] sc,
                              input logic [27:0] digs, input bit inject);
        int n;
        start_pulse(sc);
        wait_ready(inject, n);
        chk({tag, "_ready_latency"}, n, 290);
        chk({tag, "_busy_done"}, int'(busy), 0);
        check_digits(tag, digs);
    endtask

    initial begin
        logic [6:0] code;
        int         n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        score    = 14'd0;
        char_xy  = 8'd0;

        vecs[0] = '{14'd1234,  {7'h31, 7'h32, 7'h33, 7'h34}};
        vecs[1] = '{14'd0,     {7'h30, 7'h30, 7'h30, 7'h30}};
        vecs[2] = '{14'd16383, {7'h39, 7'h39, 7'h39, 7'h39}};
        vecs[3] = '{14'd9999,  {7'h39, 7'h39, 7'h39, 7'h39}};
        vecs[4] = '{14'd10000, {7'h39, 7'h39, 7'h39, 7'h39}};
        vecs[5] = '{14'd5,     {7'h30, 7'h30, 7'h30, 7'h35}};
        vecs[6] = '{14'd8050,  {7'h38, 7'h30, 7'h35, 7'h30}};
        vecs[7] = '{14'd9876,  {7'h39, 7'h38, 7'h37, 7'h36}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_char", int'(char_code), 32'h20);
        @(negedge clk);
        rst = 1'b0;
        read_at(8'h25, code);
        chk("idle_read_space", int'(code), 32'h20);

        // First build: text cells and the cell between the words.
        full_build("v0", vecs[0].sc, vecs[0].digs, 1'b0);
        read_at({4'd2, 4'd3}, code);
        chk("text_G", int'(code), 32'h47);
        read_at({4'd2, 4'd7}, code);
        chk("text_gap", int'(code), 32'h20);
        read_at({4'd2, 4'd8}, code);
        chk("text_O", int'(code), 32'h4F);
        read_at({4'd5, 4'd7}, code);
        chk("text_colon", int'(code), 32'h3A);

        for (int i = 1; i < 8; i++) begin
            full_build($sformatf("v%0d", i), vecs[i].sc, vecs[i].digs, 1'b0);
        end

        // Start while busy must not disturb timing or the latched score.
        full_build("ignore", 14'd1234, vecs[0].digs, 1'b1);

        // Reset in the middle of CONVERT.
        start_pulse(14'd3000);
        repeat (275) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(ready), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("midrst_stays_idle", int'(ready), 0);
        read_at({4'd2, 4'd3}, code);
        chk("midrst_text_hidden", int'(code), 32'h20);
        read_at({4'd5, 4'd12}, code);
        chk("midrst_digit_hidden", int'(code), 32'h20);
        full_build("s42", 14'd42, {7'h30, 7'h30, 7'h34, 7'h32}, 1'b0);

        // Raster sweep with a new address every cycle.
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            char_xy = 8'(a);
            #1;
            if (a > 0) begin
                chk($sformatf("lag_%0d", a), int'(char_code),
                    int'(exp_at(8'(a - 1), {7'h30, 7'h30, 7'h34, 7'h32})));
            end
            @(posedge clk);
            #1;
            chk($sformatf("sweep_%0d", a), int'(char_code),
                int'(exp_at(8'(a), {7'h30, 7'h30, 7'h34, 7'h32})));
        end

        // Restart from DONE drops ready on the next cycle.
        start_pulse(14'd7);
        wait_ready(1'b0, n);
        chk("restart_latency", n, 290);
        check_digits("s7", {7'h30, 7'h30, 7'h30, 7'h37});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
